// File: rtl/hack_imem_arbiter_if.sv
// Purpose: bundles the CPU fetch, debug/loader and memory-side signals of the imem arbiter.
// Latency: none (wiring only); read data arrives one cycle after a grant.
// Backpressure: req/gnt handshake; requesters hold req/addr/we/wdata until gnt.
interface hack_imem_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 16
);
    // CPU fetch port
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    // debug / loader port
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_halt;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    // single-ported memory
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  cpu_req, cpu_addr,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_addr, mem_we, mem_wdata
    );

    // requesters plus memory side
    modport master (
        output cpu_req, cpu_addr,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/hack_imem_arbiter.sv
// Purpose: shares the single-ported Hack instruction memory between CPU fetch and a debug/loader port.
// Latency: grant is combinational; read data/rvalid one cycle after the grant, writes commit on the granting edge.
// Backpressure: CPU has priority, debug is forced in after MAX_BURST CPU grants; dbg_halt blocks all CPU grants.
module hack_imem_arbiter #(
    parameter int AW        = 15,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    hack_imem_arbiter_if.slave bus
);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_CPU  = 2'd1;
    localparam logic [1:0] OWNER_DBG  = 2'd2;

    logic [7:0] burst_cnt;
    logic [1:0] owner;
    logic       cpu_gnt;
    logic       dbg_gnt;

    // Grant selection: at most one grant per cycle, nothing granted while in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!reset_n) begin
            cpu_gnt = 1'b0;
            dbg_gnt = 1'b0;
        end else if (bus.dbg_halt) begin
            dbg_gnt = bus.dbg_req;
        end else if (bus.dbg_req && burst_cnt == BURST_MAX) begin
            dbg_gnt = 1'b1;
        end else if (bus.cpu_req) begin
            cpu_gnt = 1'b1;
        end else begin
            dbg_gnt = bus.dbg_req;
        end
    end

    // Count CPU grants taken while debug is waiting; cleared once debug is served or stops asking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt <= 8'd0;
        end else if (dbg_gnt || !bus.dbg_req) begin
            burst_cnt <= 8'd0;
        end else if (cpu_gnt && burst_cnt != BURST_MAX) begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end

    // Remember who issued the read so the returning word is steered to the right valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner <= OWNER_NONE;
        end else if (cpu_gnt) begin
            owner <= OWNER_CPU;
        end else if (dbg_gnt && !bus.dbg_we) begin
            owner <= OWNER_DBG;
        end else begin
            owner <= OWNER_NONE;
        end
    end

    // With no grant the memory sees a harmless CPU-address read that nobody collects.
    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.mem_addr   = dbg_gnt ? bus.dbg_addr : bus.cpu_addr;
    assign bus.mem_we     = dbg_gnt & bus.dbg_we;
    assign bus.mem_wdata  = bus.dbg_wdata;

    assign bus.cpu_rvalid = (owner == OWNER_CPU);
    assign bus.dbg_rvalid = (owner == OWNER_DBG);
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dbg_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_hack_imem_arbiter.sv
// Purpose: randomized and directed check of hack_imem_arbiter against a reference model.
// Latency: expects grants in the issuing cycle and read data one cycle later.
// Backpressure: requesters hold their request until granted; debug may drop its request.
module tb_hack_imem_arbiter;
    localparam int AW        = 15;
    localparam int DW        = 16;
    localparam int MAX_BURST = 8;
    localparam int DEPTH     = 1 << AW;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    hack_imem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    hack_imem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int            cyc;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t cpu_q[$];
    exp_t dbg_q[$];

    logic [DW-1:0] mem_array [0:DEPTH-1];
    logic [DW-1:0] ref_mem   [0:DEPTH-1];

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int streak = 0;

    function automatic logic [DW-1:0] rom_word(input int a);
        return 16'((a * 40503) ^ 16'h3C5A);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory environment: synchronous read, write on the edge
    always @(posedge clock) begin
        if (bus.mem_we) mem_array[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem_array[bus.mem_addr];
    end

    always @(posedge clock) cyc <= cyc + 1;

    // monitor: pops the scoreboard whenever a read granted in an earlier cycle is due
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
            chk("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 0);
        end else begin
            if (cpu_q.size() > 0 && cpu_q[0].cyc < cyc) begin
                e = cpu_q.pop_front();
                chk("cpu_rvalid", 32'(bus.cpu_rvalid), 1);
                if (bus.cpu_rvalid) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.dat));
            end else begin
                chk("cpu_rvalid_idle", 32'(bus.cpu_rvalid), 0);
            end
            if (dbg_q.size() > 0 && dbg_q[0].cyc < cyc) begin
                e = dbg_q.pop_front();
                chk("dbg_rvalid", 32'(bus.dbg_rvalid), 1);
                if (bus.dbg_rvalid) chk("dbg_rdata", 32'(bus.dbg_rdata), 32'(e.dat));
            end else begin
                chk("dbg_rvalid_idle", 32'(bus.dbg_rvalid), 0);
            end
        end
    end

    // One clock cycle of stimulus; the model decides who should win and queues the expected read data.
    task automatic cycle(input logic rn, input logic cr, input logic [AW-1:0] ca,
                         input logic dr, input logic dwe, input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd, input logic dh,
                         output logic gc, output logic gd);
        logic ec;
        logic ed;
        reset_n       = rn;
        bus.cpu_req   = cr;
        bus.cpu_addr  = ca;
        bus.dbg_req   = dr;
        bus.dbg_we    = dwe;
        bus.dbg_addr  = da;
        bus.dbg_wdata = dwd;
        bus.dbg_halt  = dh;
        if (!rn) begin
            cpu_q.delete();
            dbg_q.delete();
            streak = 0;
        end
        @(negedge clock);
        ec = 1'b0;
        ed = 1'b0;
        if (rn) begin
            if (dh)                            ed = dr;
            else if (dr && streak >= MAX_BURST) ed = 1'b1;
            else if (cr)                       ec = 1'b1;
            else                               ed = dr;
        end
        chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(ec));
        chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(ed));
        chk("mem_we", 32'(bus.mem_we), 32'(ed & dwe));
        chk("mem_addr", 32'(bus.mem_addr), ed ? 32'(da) : 32'(ca));
        if (ed && dwe) chk("mem_wdata", 32'(bus.mem_wdata), 32'(dwd));
        if (ec) cpu_q.push_back('{cyc, ref_mem[ca]});
        if (ed && !dwe) dbg_q.push_back('{cyc, ref_mem[da]});
        if (ed && dwe) ref_mem[da] = dwd;
        if (!rn || ed || !dr) streak = 0;
        else if (ec && streak < MAX_BURST) streak++;
        gc = ec;
        gd = ed;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic gc, gd;
        logic cr, dr, dwe, dh, pc, pd;
        logic [AW-1:0] ca, da;
        logic [DW-1:0] dwd;
        int cnt;

        for (int i = 0; i < DEPTH; i++) begin
            mem_array[i] = rom_word(i);
            ref_mem[i]   = rom_word(i);
        end

        // reset held with both requests up
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 15'd5, 1'b1, 1'b0, 15'h10, 16'h0, 1'b0, gc, gd);
        // release: CPU wins the first cycle
        cycle(1'b1, 1'b1, 15'd0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);

        // CPU-only stream
        for (int a = 0; a < 6; a++) cycle(1'b1, 1'b1, 15'(a), 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);
        cycle(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);

        // starvation: 8 CPU grants then one debug read, repeating
        cnt = 0;
        for (int i = 0; i < 27; i++) begin
            cycle(1'b1, 1'b1, 15'(i), 1'b1, 1'b0, 15'h10, 16'h0, 1'b0, gc, gd);
            if (bus.dbg_rvalid) cnt++;
        end
        cycle(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);
        chk("starve_dbg_reads", 32'(cnt + 32'(bus.dbg_rvalid)), 3);

        // halt + program load, CPU keeps requesting
        cnt = 0;
        cycle(1'b1, 1'b1, 15'h100, 1'b1, 1'b1, 15'h3, 16'hEC10, 1'b1, gc, gd);
        cycle(1'b1, 1'b1, 15'h100, 1'b1, 1'b0, 15'h3, 16'h0, 1'b1, gc, gd);
        chk("load_readback", 32'(bus.dbg_rdata), 32'hEC10);
        cycle(1'b1, 1'b1, 15'h3, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);
        chk("cpu_sees_load", 32'(bus.cpu_rdata), 32'hEC10);

        // debug drops its request before a grant, then re-asserts: streak starts from zero
        cycle(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 15'(i), 1'b1, 1'b0, 15'h20, 16'h0, 1'b0, gc, gd);
        cycle(1'b1, 1'b1, 15'd3, 1'b0, 1'b0, 15'h20, 16'h0, 1'b0, gc, gd);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 15'(i), 1'b1, 1'b0, 15'h21, 16'h0, 1'b0, gc, gd);
            if (bus.cpu_rvalid) cnt++;
        end
        chk("drop_cpu_burst", 32'(cnt), 8);
        cycle(1'b1, 1'b1, 15'd9, 1'b1, 1'b0, 15'h21, 16'h0, 1'b0, gc, gd);
        chk("drop_dbg_after_burst", 32'(bus.dbg_rvalid), 1);
        // both idle: no rvalid next cycle (monitor checks)
        cycle(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);
        cycle(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);

        // async reset right after a debug read grant kills its rvalid
        cycle(1'b1, 1'b0, 15'd0, 1'b1, 1'b0, 15'h10, 16'h0, 1'b1, gc, gd);
        reset_n = 1'b0;
        #1;
        chk("rst_kills_dbg_rvalid", 32'(bus.dbg_rvalid), 0);
        cycle(1'b0, 1'b0, 15'd0, 1'b1, 1'b1, 15'h10, 16'hFFFF, 1'b1, gc, gd);
        cycle(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);
        cycle(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);
        cycle(1'b1, 1'b1, 15'h10, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);

        // randomized traffic with held requests, occasional debug drops and halts
        pc = 1'b0; pd = 1'b0;
        cr = 1'b0; ca = '0; dr = 1'b0; dwe = 1'b0; da = '0; dwd = '0;
        for (int i = 0; i < 500; i++) begin
            if (!pc) begin
                cr = ($urandom_range(0, 3) != 0);
                ca = 15'($urandom_range(0, 31));
            end
            if (!pd) begin
                dr  = ($urandom_range(0, 2) == 0);
                dwe = ($urandom_range(0, 2) == 0);
                da  = 15'($urandom_range(0, 31));
                dwd = 16'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                dr = 1'b0;
            end
            dh = ($urandom_range(0, 15) == 0);
            cycle(1'b1, cr, ca, dr, dwe, da, dwd, dh, gc, gd);
            pc = cr && !gc;
            pd = dr && !gd;
        end

        // drain
        cycle(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);
        cycle(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, gc, gd);
        chk("cpu_q_drained", 32'(cpu_q.size()), 0);
        chk("dbg_q_drained", 32'(dbg_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
